// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Holds the program counter, issues icache reads and
// hands each fetched word plus its PC+4 to the IF/ID latch through that latch's
// enable/flush strobes. Handles branch/jump redirects, hazard stalls, icache
// misses and halt.
//
// Parameters:
//   PC_INIT       PC value loaded on reset
//
// Ports:
//   CLK           clock, all state updates on posedge
//   nRST          asynchronous active-low reset
//   ihit          icache returns valid imemload for imemaddr this cycle
//   imemload      instruction word from icache
//   imemREN       icache read request
//   imemaddr      icache read address (always the current pc)
//   stall         hazard unit: hold IF/ID contents
//   redirect      taken branch/jump resolved downstream
//   redirect_pc   redirect target (low two bits ignored)
//   halt          halt instruction reached a later stage
//   imemload_out  instruction to IF/ID (zero when no hit)
//   npc_out       pc+4 to IF/ID
//   ifid_enable   IF/ID update strobe
//   ifid_flush    IF/ID flush strobe
//   halted        fetch permanently stopped (until reset)
//
// Optional build macro:
//   FETCH_PERF_EN adds fetch_count and miss_cycles saturating counters.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] imemload_out,
  output logic [31:0] npc_out,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] miss_cycles
`endif
);

  // StKill: a redirect arrived while a miss was in flight; wait for that
  // stale hit, drop its word, then resume fetching at r_target.
  typedef enum logic [1:0] {StRun, StKill, StHalt} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic        r_halted;

  logic [31:0] w_redirect_pc;
  logic [31:0] w_npc;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_npc         = r_pc + 32'd4;

  always_comb begin
    imemaddr     = r_pc;
    npc_out      = w_npc;
    imemREN      = !r_halted;
    halted       = r_halted;
    imemload_out = ihit ? imemload : 32'h0;
    // halt outranks redirect, so a same-cycle redirect does not flush.
    ifid_flush   = (r_state != StHalt) && !halt && redirect;
    ifid_enable  = (r_state == StRun) && !halt && !redirect && !stall && ihit;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= StRun;
      r_pc     <= PC_INIT;
      r_target <= 32'h0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        StRun: begin
          if (halt) begin
            r_state  <= StHalt;
            r_halted <= 1'b1;
          end else if (redirect) begin
            if (ihit) begin
              r_pc <= w_redirect_pc;
            end else begin
              r_target <= w_redirect_pc;
              r_state  <= StKill;
            end
          end else if (!stall && ihit) begin
            r_pc <= w_npc;
          end
        end
        StKill: begin
          if (halt) begin
            r_state  <= StHalt;
            r_halted <= 1'b1;
          end else begin
            if (redirect) begin
              r_target <= w_redirect_pc;
            end
            if (ihit) begin
              // A redirect in the same cycle as the stale hit is the newest target.
              r_pc    <= redirect ? w_redirect_pc : r_target;
              r_state <= StRun;
            end
          end
        end
        StHalt: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= StRun;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_miss_cycles;
  logic        w_miss;

  assign w_miss      = imemREN && !ihit;
  assign fetch_count = r_fetch_count;
  assign miss_cycles = r_miss_cycles;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fetch_count <= 32'h0;
      r_miss_cycles <= 32'h0;
    end else if (r_state != StHalt) begin
      if (ifid_enable && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_miss && (r_miss_cycles != 32'hFFFF_FFFF)) begin
        r_miss_cycles <= r_miss_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage with a directed sequence followed by randomized traffic.
// A behavioural model of the fetch rules predicts every output; a compare
// process checks the DUT against it each cycle. Literal expectations in the
// directed part pin the model itself.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload_out;
  logic [31:0] npc_out;
  logic        ifid_enable;
  logic        ifid_flush;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] miss_cycles;
`endif

  int checks = 0;
  int failures = 0;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .imemload     (imemload),
    .imemREN      (imemREN),
    .imemaddr     (imemaddr),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .imemload_out (imemload_out),
    .npc_out      (npc_out),
    .ifid_enable  (ifid_enable),
    .ifid_flush   (ifid_flush),
    .halted       (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count),
    .miss_cycles  (miss_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // m_discard: a redirect happened during a miss; the next hit is stale.
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_halted;
  bit          m_discard;
  logic [31:0] m_fc;
  logic [31:0] m_mc;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic bit exp_en();
    return !m_halted && !m_discard && !halt && !redirect && !stall && ihit;
  endfunction

  function automatic bit exp_flush();
    return !m_halted && !halt && redirect;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_pc      <= 32'h0;
      m_tgt     <= 32'h0;
      m_halted  <= 1'b0;
      m_discard <= 1'b0;
      m_fc      <= 32'h0;
      m_mc      <= 32'h0;
    end else if (!m_halted) begin
      if (exp_en() && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
      if (!ihit && m_mc != 32'hFFFF_FFFF) m_mc <= m_mc + 1;
      if (halt) begin
        m_halted <= 1'b1;
      end else if (m_discard) begin
        if (redirect) m_tgt <= align(redirect_pc);
        if (ihit) begin
          m_pc      <= redirect ? align(redirect_pc) : m_tgt;
          m_discard <= 1'b0;
        end
      end else if (redirect) begin
        if (ihit) m_pc <= align(redirect_pc);
        else begin
          m_tgt     <= align(redirect_pc);
          m_discard <= 1'b1;
        end
      end else if (!stall && ihit) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: inputs change at negedge, outputs settle, check at +2.
  always @(negedge CLK) begin
    #2;
    chk("imemaddr", imemaddr, m_pc);
    chk("imemREN", {31'h0, imemREN}, {31'h0, !m_halted});
    chk("npc_out", npc_out, m_pc + 32'd4);
    chk("imemload_out", imemload_out, ihit ? imemload : 32'h0);
    chk("ifid_enable", {31'h0, ifid_enable}, {31'h0, exp_en()});
    chk("ifid_flush", {31'h0, ifid_flush}, {31'h0, exp_flush()});
    chk("halted", {31'h0, halted}, {31'h0, m_halted});
`ifdef FETCH_PERF_EN
    chk("fetch_count", fetch_count, m_fc);
    chk("miss_cycles", miss_cycles, m_mc);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit h, input logic [31:0] ld, input bit st, input bit rd,
                     input logic [31:0] rp, input bit hl);
    @(negedge CLK);
    ihit        = h;
    imemload    = ld;
    stall       = st;
    redirect    = rd;
    redirect_pc = rp;
    halt        = hl;
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk({"lit_", name}, act, exp);
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    lit("rst_addr", imemaddr, 32'h0);
    lit("rst_ren", {31'h0, imemREN}, 32'h1);
    lit("rst_halted", {31'h0, halted}, 32'h0);
    nRST = 1'b1;

    // Hits, a 3-cycle miss, another hit
    cyc(1, 32'h11, 0, 0, 0, 0);
    lit("h1_addr", imemaddr, 32'h0);
    lit("h1_npc", npc_out, 32'h4);
    lit("h1_en", {31'h0, ifid_enable}, 32'h1);
    lit("h1_load", imemload_out, 32'h11);
    cyc(1, 32'h22, 0, 0, 0, 0);
    lit("h2_addr", imemaddr, 32'h4);
    lit("h2_npc", npc_out, 32'h8);
    repeat (3) begin
      cyc(0, 32'h99, 0, 0, 0, 0);
      lit("miss_addr", imemaddr, 32'h8);
      lit("miss_en", {31'h0, ifid_enable}, 32'h0);
      lit("miss_load", imemload_out, 32'h0);
    end
    cyc(1, 32'h33, 0, 0, 0, 0);
    lit("h3_addr", imemaddr, 32'h8);
    lit("h3_npc", npc_out, 32'hC);

    // Redirect on a hit, low bits of target dropped
    cyc(1, 32'h44, 0, 1, 32'h0000_0103, 0);
`ifdef FETCH_PERF_EN
    lit("perf_fetch", fetch_count, 32'd3);
    lit("perf_miss", miss_cycles, 32'd3);
`endif
    lit("rh_addr", imemaddr, 32'hC);
    lit("rh_flush", {31'h0, ifid_flush}, 32'h1);
    lit("rh_en", {31'h0, ifid_enable}, 32'h0);

    // Redirect on a miss: stale hit dropped, then target
    cyc(0, 0, 0, 1, 32'h0000_0200, 0);
    lit("rm_addr", imemaddr, 32'h100);
    lit("rm_flush", {31'h0, ifid_flush}, 32'h1);
    repeat (3) begin
      cyc(0, 0, 0, 0, 0, 0);
      lit("kill_addr", imemaddr, 32'h100);
      lit("kill_flush", {31'h0, ifid_flush}, 32'h0);
    end
    cyc(1, 32'h0000_DEAD, 0, 0, 0, 0);
    lit("stale_en", {31'h0, ifid_enable}, 32'h0);

    // Stall with hits, then release
    repeat (3) begin
      cyc(1, 32'h55, 1, 0, 0, 0);
      lit("stall_addr", imemaddr, 32'h200);
      lit("stall_en", {31'h0, ifid_enable}, 32'h0);
      lit("stall_ren", {31'h0, imemREN}, 32'h1);
    end
    cyc(1, 32'h66, 0, 0, 0, 0);
    lit("rel_en", {31'h0, ifid_enable}, 32'h1);

    // npc wrap at top of address space
    cyc(1, 32'h77, 0, 1, 32'hFFFF_FFFF, 0);
    lit("rel_next_addr", imemaddr, 32'h204);
    cyc(1, 32'h88, 0, 0, 0, 0);
    lit("wrap_addr", imemaddr, 32'hFFFF_FFFC);
    lit("wrap_npc", npc_out, 32'h0);
    cyc(1, 32'h0, 0, 0, 0, 0);
    lit("wrap_next", imemaddr, 32'h0);

    // Reset asserted in the middle of a miss
    cyc(0, 0, 0, 0, 0, 0);
    lit("pre_rst_addr", imemaddr, 32'h4);
    @(negedge CLK);
    ihit = 1'b0;
    nRST = 1'b0;
    #1;
    lit("midrst_addr", imemaddr, 32'h0);
    nRST = 1'b1;

    // halt beats redirect; later redirects ignored
    cyc(1, 32'h1, 0, 0, 0, 0);
    cyc(1, 32'h2, 0, 1, 32'h300, 1);
    lit("halt_flush", {31'h0, ifid_flush}, 32'h0);
    lit("halt_en", {31'h0, ifid_enable}, 32'h0);
    cyc(1, 32'h3, 0, 1, 32'h400, 0);
    lit("halted_ren", {31'h0, imemREN}, 32'h0);
    lit("halted_out", {31'h0, halted}, 32'h1);
    lit("halted_flush", {31'h0, ifid_flush}, 32'h0);
    lit("halted_addr", imemaddr, 32'h4);
    cyc(1, 32'h4, 0, 0, 0, 0);
    lit("halted_stays", imemaddr, 32'h4);

    @(negedge CLK);
    nRST = 1'b0;
    #1;
    nRST = 1'b1;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rp;
      rp = $urandom;
      if ($urandom_range(7) == 0) rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if (($urandom_range(199) == 0) || (m_halted && $urandom_range(7) == 0)) begin
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
      end else begin
        cyc($urandom_range(99) < 60, $urandom, $urandom_range(99) < 20,
            $urandom_range(99) < 10, rp, $urandom_range(199) == 0);
      end
    end

    @(negedge CLK);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
